// File: rtl/proc_pkg.sv
// Shared constants and types for the scalar/vector FP core front end.
package proc_pkg;

    // Default widths and boot address for the fetch stage
    localparam int          DEF_ADDR_W   = 32;
    localparam int          DEF_INSTR_W  = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    // Main-decoder opcodes (instr[31:26])
    localparam logic [5:0] OP_BEQ = 6'b100000;
    localparam logic [5:0] OP_J   = 6'b100010;

    // Fetch FSM: IDLE after reset, REQ while streaming, DROP while
    // waiting out a stale request that a redirect overtook
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry (instr, pc) skid buffer that absorbs the word returned while
// decode is stalled. Clear beats load, load beats drain.
module fetch_skid_buf #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               drain,
    input  logic               clear,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_pc,
    output logic               full,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);

    // Occupancy flag plus payload; payload only written on load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= in_instr;
            pc    <= in_pc;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register: owns the PC, issues one
// outstanding request at a time, absorbs decode stalls through a one-entry
// skid buffer and applies downstream branch/jump redirects.
module fetch_unit
    import proc_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC[ADDR_W-1:0]
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall_d,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               valid_d,
    output logic [INSTR_W-1:0] instr_d,
    output logic [5:0]         opcode_d,
    output logic [ADDR_W-1:0]  pc_d,
    output logic [ADDR_W-1:0]  pcplus4_d
);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc_f;
    logic [ADDR_W-1:0]  drop_target;
    logic               skid_full;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;
    logic               fire;
    logic               take;
    logic               mem_word;
    logic               skid_load;
    logic               skid_drain;
    logic [ADDR_W-1:0]  redir_aligned;

    // A full skid blocks new requests; DROP keeps the stale request alive
    // with its original address until memory answers it.
    assign imem_req      = (state == DROP) || ((state == REQ) && !skid_full);
    assign imem_addr     = pc_f;
    assign fire          = imem_req && imem_ready;
    assign mem_word      = fire && (state == REQ);
    assign take          = !valid_d || !stall_d;
    assign redir_aligned = redirect_pc & ~ADDR_W'(3);
    assign skid_load     = !redirect && mem_word && !take;
    assign skid_drain    = !redirect && take && skid_full;
    assign opcode_d      = instr_d[31:26];

    fetch_skid_buf #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .drain   (skid_drain),
        .clear   (redirect),
        .in_instr(imem_rdata),
        .in_pc   (pc_f),
        .full    (skid_full),
        .instr   (skid_instr),
        .pc      (skid_pc)
    );

    // PC and fetch FSM; a redirect with a pending unanswered request parks
    // the target in drop_target until the stale word comes back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc_f        <= RESET_PC;
            drop_target <= RESET_PC;
        end else begin
            unique case (state)
                IDLE: begin
                    if (redirect) pc_f <= redir_aligned;
                    state <= REQ;
                end
                REQ: begin
                    if (redirect) begin
                        if (imem_req && !imem_ready) begin
                            state       <= DROP;
                            drop_target <= redir_aligned;
                        end else begin
                            pc_f <= redir_aligned;
                        end
                    end else if (fire) begin
                        pc_f <= pc_f + ADDR_W'(4);
                    end
                end
                DROP: begin
                    if (imem_ready) begin
                        pc_f  <= redirect ? redir_aligned : drop_target;
                        state <= REQ;
                    end else if (redirect) begin
                        drop_target <= redir_aligned;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // IF/ID register: skid contents always go first to keep program order
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_d   <= 1'b0;
            instr_d   <= '0;
            pc_d      <= '0;
            pcplus4_d <= '0;
        end else if (redirect) begin
            valid_d <= 1'b0;
        end else if (take) begin
            if (skid_full) begin
                valid_d   <= 1'b1;
                instr_d   <= skid_instr;
                pc_d      <= skid_pc;
                pcplus4_d <= skid_pc + ADDR_W'(4);
            end else if (mem_word) begin
                valid_d   <= 1'b1;
                instr_d   <= imem_rdata;
                pc_d      <= pc_f;
                pcplus4_d <= pc_f + ADDR_W'(4);
            end else begin
                valid_d <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and IF/ID pipeline register of the scalar/vector FP core. It owns the PC, issues single-outstanding requests to instruction memory over a req/ready handshake, and absorbs decode stalls with a one-entry skid buffer. It also applies branch/jump redirects and presents `instr_d`, its `opcode_d` field and the PC to the decode stage, where `opcode_d` drives the main control decoder.

## Interface
- `ADDR_W`, 32, PC / instruction-memory address width
- `INSTR_W`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; one clock, no other clock domain
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  ADDR_W  fetch address; stable while `imem_req`=1 and `imem_ready`=0
- `imem_ready`  in  1  memory accepts request and returns `imem_rdata` in the same cycle
- `imem_rdata`  in  INSTR_W  instruction word, valid only when `imem_req`&&`imem_ready`
- `stall_d`  in  1  decode cannot accept; IF/ID holds
- `redirect`  in  1  taken branch (beq/blt) or jump resolved downstream
- `redirect_pc`  in  ADDR_W  target for `redirect`
- `valid_d`  out  1  IF/ID holds a live instruction
- `instr_d`  out  INSTR_W  IF/ID instruction
- `opcode_d`  out  6  `instr_d[31:26]`, to the main decoder
- `pc_d`  out  ADDR_W  address of `instr_d`
- `pcplus4_d`  out  ADDR_W  `pc_d + 4`, modulo 2^ADDR_W

## Operation
- Reset values:
  - outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `valid_d`=0, `instr_d`=0, `pc_d`=0, `pcplus4_d`=0
  - internal: state=IDLE, skid empty
- States:
  - IDLE: `imem_req`=0. Next state is REQ, after exactly one cycle following reset release.
  - REQ: `imem_req`=1, `imem_addr`=`pc_f`.
    - On `imem_ready`, the word goes to IF/ID if IF/ID is free or draining (`!valid_d || !stall_d`), otherwise to the skid.
    - Then `pc_f += 4`.
    - Stays in REQ unless the skid is full. With a full skid, REQ deasserts `imem_req` (no new request issued) until the skid drains.
  - DROP: a redirect arrived while a request was pending without ready.
    - `imem_req` stays 1 with the old address until ready.
    - The returned word is discarded.
    - `pc_f` = latched `redirect_pc`, then back to REQ.
- Skid: one entry (instr, pc). It drains into IF/ID on the first cycle with `!stall_d`. IF/ID is always loaded from the skid before any new memory data; order is preserved.
- Redirect (highest priority, overrides `stall_d`):
  - next cycle: `valid_d`=0, skid cleared, any same-cycle returned word discarded
  - no request pending: `pc_f`=`redirect_pc` and REQ next cycle
  - request pending without ready: go to DROP
- Bubbles: when `valid_d`=0, `instr_d`/`pc_d` are don't-care. Decode gates every write enable with `valid_d`.
- PC arithmetic wraps modulo 2^ADDR_W. The low 2 bits of `redirect_pc` are forced to 0.

## Timing
- Zero-wait memory (ready same cycle as req): first `valid_d`=1 two cycles after reset release (IDLE, then REQ capture); afterwards, one instruction per cycle.
- Fetch-to-decode latency: data accepted at edge t, visible on `instr_d` after edge t.
- `stall_d` at cycle t:
  - IF/ID holds at edge t.
  - A word returned at t goes to the skid.
  - No further request is accepted while the skid is full.
- Redirect at t: `valid_d`=0 after edge t. The first redirected word is in IF/ID after edge t+1 (zero-wait, no pending request).
- `reset` asserted mid-request: immediate return to reset values. The memory must tolerate an abandoned request.

## Structure
- `proc_pkg`:
  - `ADDR_W`, `INSTR_W`, `RESET_PC` defaults
  - opcode localparams (`OP_J`=6'b100010, `OP_BEQ`=6'b100000, …)
  - `fetch_state_t` enum {IDLE, REQ, DROP}
- Sub-module `fetch_skid_buf`: one-entry (instr, pc) buffer with load/drain/clear.
- PC/FSM and IF/ID register live in `fetch_unit`.

## Test plan
- Reset release, ready tied 1 → `imem_addr` 0,4,8,…; `pc_d`=0 with `valid_d`=1 two cycles after release; `pcplus4_d`=4.
- `stall_d`=1 for 3 cycles at `pc_d`=8 with ready=1 → `instr_d`@8 held; @12 in the skid; no request for 16 issued; after release, 12 then 16 in order, none lost or duplicated.
- Redirect to 0x40 with no request pending → next cycle `valid_d`=0; `imem_addr`=0x40; then `pc_d`=0x40.
- Ready held 0 for 4 cycles at address 0x20, redirect to 0x80 in wait cycle 2 → address stays 0x20 until ready; that word is dropped; next request 0x80; `valid_d` never shows 0x20.
- Redirect and `stall_d` in the same cycle, skid full → both IF/ID and skid invalid next cycle; fetch resumes at the target.
- `reset` asserted while `imem_req`=1 with ready=0 → `imem_req`=0 and `valid_d`=0 immediately; restart at `RESET_PC`.
